start_stop_sequencer: RTL and testbench
=======================================

# start_stop_sequencer

Controller that owns the `start` strobe of a downstream unit and checks each transaction's completion against the two legal response shapes. The fast shape is `a` one cycle after `start`. The slow shape is `b` one cycle after `start`, then `stop` two cycles after `b`. The block accepts requests over a valid/ready handshake, issues one `start` pulse per attempt, and retries failed attempts. It reports pass/fail per request and keeps saturating pass/fail counters for status readback.

## Interface
- `CNT_W`, 8, width of the pass/fail counters
- `MAX_RETRY`, 2, extra attempts after a failed one (0..7)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request pending
- `req_ready`  out  1  block can accept a request
- `start`  out  1  single-cycle start strobe to downstream unit
- `a`  in  1  fast-path completion
- `b`  in  1  slow-path acknowledge
- `stop`  in  1  slow-path completion
- `done`  out  1  one-cycle pulse: request passed
- `err`  out  1  one-cycle pulse: request failed after all attempts
- `busy`  out  1  request in flight
- `pass_cnt`  out  CNT_W  saturating count of passed requests
- `fail_cnt`  out  CNT_W  saturating count of failed requests

## Operation
- Reset: every output is 0 except `req_ready`, which is 1. The FSM goes to IDLE, counters clear, and the retry count clears.
- States: IDLE, START, CHK, SLOW1, SLOW2, GAP, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready` -> START, retry count cleared.
- START:
  - `start`=1 for exactly this cycle -> CHK.
- CHK (cycle T+1 after start at T):
  - `a`=1 -> RESP with pass. `a` takes priority when `a` and `b` are both 1.
  - Else `b`=1 -> SLOW1.
  - Else -> attempt fails.
- SLOW1 (T+2) -> SLOW2 unconditionally. `a`, `b` and `stop` are ignored.
- SLOW2 (T+3):
  - `stop`=1 -> RESP with pass.
  - Else -> attempt fails.
- Attempt fails:
  - If retry count < MAX_RETRY: increment it and go to GAP.
  - Otherwise -> RESP with fail.
- GAP:
  - `start`=0 for one cycle so every attempt is a clean rising edge -> START.
- RESP:
  - Pulse `done` or `err`.
  - Increment `pass_cnt` or `fail_cnt`; each saturates at 2^CNT_W−1 and never wraps.
  - -> IDLE.
- `busy`=1 in every state except IDLE.
- `req_valid` is ignored while `req_ready`=0. There is no queue; an upstream request stays pending until it is accepted.
- Async reset mid-transaction drops the request with no `done`/`err`. `start` deasserts immediately on reset assertion.

## Timing
- Accept at edge E: `start` high in the cycle after E.
- Fast pass: `done` 2 cycles after the `start` cycle. Back-to-back requests give one `start` every 4 cycles at best.
- Slow pass: `done` 4 cycles after the `start` cycle.
- Each failed attempt costs 2 cycles (no `b`) or 4 cycles (`b` but no `stop`), plus 1 GAP cycle before the re-issued `start`.
- Outputs are registered: `start`, `done`, `err`, `busy` and `req_ready` are flop outputs with no combinational input-to-output path.
- `a`, `b` and `stop` outside the CHK/SLOW2 sample windows have no effect.

## Configuration
- `SEQ_RETRY_EN`:
  - Defined: failed attempts retry up to MAX_RETRY times as above.
  - Undefined: the first failed attempt goes straight to RESP with fail, GAP is never entered, and MAX_RETRY is unused.

## Test plan
- Fast pass: accept request; `a`=1 in the cycle after `start` -> `done` pulse 2 cycles after `start`, `pass_cnt`=1, `fail_cnt`=0, one `start` pulse total.
- Slow pass: `b`=1 at T+1, `stop`=1 at T+3 -> `done` at T+4. Then `b` at T+1 with `stop` at T+2 only (wrong cycle) -> attempt fails.
- Retry, MAX_RETRY=2, `SEQ_RETRY_EN` defined: no response at all -> three `start` pulses, each separated by ≥1 low cycle, then `err`, `fail_cnt`=1. With the macro undefined: one `start`, then `err`.
- Priority: `a`=1 and `b`=1 together at T+1 -> fast pass at T+2, `stop` ignored.
- Saturation: CNT_W=2, six fast passes -> `pass_cnt` stays 3.
- Reset mid-SLOW1: assert `rst_n`=0 -> all outputs 0, `req_ready`=1 after release, no `done`/`err`, counters 0.

Source files
------------

// File: rtl/start_stop_sequencer.sv
// Start/stop sequencer: issues one start strobe per attempt, checks fast (a) or slow (b..stop) completion,
// retries failed attempts when SEQ_RETRY_EN is defined, and keeps saturating pass/fail counters.
module start_stop_sequencer #(
    parameter int CNT_W     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             stop,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [2:0] {
        IDLE, START, CHK, SLOW1, SLOW2, GAP, RESP
    } state_t;

`ifdef SEQ_RETRY_EN
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
`else
    // Retries disabled: a zero limit sends the first failed attempt straight to RESP.
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY) & 3'd0;
`endif

    state_t           state_q, state_d;
    logic [2:0]       retry_q, retry_d;
    logic             start_q, done_q, err_q, busy_q, ready_q;
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
    logic             fin_pass, fin_fail, att_fail;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        fin_pass = 1'b0;
        fin_fail = 1'b0;
        att_fail = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = START;
                    retry_d = 3'd0;
                end
            end
            START: state_d = CHK;
            CHK: begin
                if (a) begin
                    state_d  = RESP;
                    fin_pass = 1'b1;
                end else if (b) begin
                    state_d = SLOW1;
                end else begin
                    att_fail = 1'b1;
                end
            end
            SLOW1: state_d = SLOW2;
            SLOW2: begin
                if (stop) begin
                    state_d  = RESP;
                    fin_pass = 1'b1;
                end else begin
                    att_fail = 1'b1;
                end
            end
            GAP:     state_d = START;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (att_fail) begin
            if (retry_q < RETRY_LIM) begin
                retry_d = retry_q + 3'd1;
                state_d = GAP;
            end else begin
                state_d  = RESP;
                fin_fail = 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so every output leaves a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            retry_q    <= 3'd0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            start_q <= (state_d == START);
            done_q  <= fin_pass;
            err_q   <= fin_fail;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == IDLE);
            if (fin_pass && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + 1'b1;
            if (fin_fail && (fail_cnt_q != '1)) fail_cnt_q <= fail_cnt_q + 1'b1;
        end
    end

    assign req_ready = ready_q;
    assign start     = start_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_start_stop_sequencer.sv
// Directed bench for start_stop_sequencer (CNT_W=2, MAX_RETRY=2); expectations follow SEQ_RETRY_EN.
module tb_start_stop_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, a, b, stop;
    logic       req_ready, start, done, err, busy;
    logic [1:0] pass_cnt, fail_cnt;

    int total = 0;
    int bad   = 0;

    int starts, first_s, last_s, min_gap, lat;
    logic got_done, got_err;

    always #5 clk = ~clk;

    start_stop_sequencer #(.CNT_W(2), .MAX_RETRY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .start(start), .a(a), .b(b), .stop(stop),
        .done(done), .err(err), .busy(busy),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one request from IDLE and answers every start pulse the same way.
    task automatic txn(input logic ra, input logic rb, input logic rs2_wrong, input logic rs3);
        starts = 0; first_s = -1; last_s = -100; min_gap = 99; lat = -1;
        got_done = 1'b0; got_err = 1'b0;
        req_valid = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            a = 1'b0; b = 1'b0; stop = 1'b0;
            if (c == 1) chk("ready_low_when_busy", int'(req_ready), 0);
            if (start) begin
                if (first_s < 0) first_s = c;
                else if (c - last_s - 1 < min_gap) min_gap = c - last_s - 1;
                last_s = c;
                starts++;
            end
            if (c == last_s + 1) begin a = ra; b = rb; end
            if (c == last_s + 2) stop = rs2_wrong;
            if (c == last_s + 3) stop = rs3;
            if (done || err) begin
                got_done = done; got_err = err; lat = c - last_s;
                break;
            end
        end
        a = 1'b0; b = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        chk("back_to_idle_ready", int'(req_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; a = 1'b0; b = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_err", int'({done, err}), 0);
        chk("rst_cnts", int'({pass_cnt, fail_cnt}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fast pass
        txn(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fast_first_start", first_s, 1);
        chk("fast_starts", starts, 1);
        chk("fast_done", int'(got_done), 1);
        chk("fast_lat", lat, 2);
        chk("fast_pass_cnt", int'(pass_cnt), 1);
        chk("fast_fail_cnt", int'(fail_cnt), 0);

        // Slow pass
        txn(1'b0, 1'b1, 1'b0, 1'b1);
        chk("slow_done", int'(got_done), 1);
        chk("slow_lat", lat, 4);
        chk("slow_starts", starts, 1);
        chk("slow_pass_cnt", int'(pass_cnt), 2);

        // Slow shape with stop one cycle early
`ifdef SEQ_RETRY_EN
        txn(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrong_stop_starts", starts, 3);
        chk("wrong_stop_gap", min_gap, 4);
`else
        txn(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrong_stop_starts", starts, 1);
`endif
        chk("wrong_stop_err", int'(got_err), 1);
        chk("wrong_stop_done", int'(got_done), 0);
        chk("wrong_stop_lat", lat, 4);
        chk("wrong_stop_fail_cnt", int'(fail_cnt), 1);

        // No response at all
        txn(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_RETRY_EN
        chk("noresp_starts", starts, 3);
        chk("noresp_gap", min_gap, 2);
`else
        chk("noresp_starts", starts, 1);
`endif
        chk("noresp_err", int'(got_err), 1);
        chk("noresp_lat", lat, 2);
        chk("noresp_fail_cnt", int'(fail_cnt), 2);
        chk("noresp_pass_cnt", int'(pass_cnt), 2);

        // a and b together: fast path wins
        txn(1'b1, 1'b1, 1'b0, 1'b1);
        chk("prio_done", int'(got_done), 1);
        chk("prio_lat", lat, 2);
        chk("prio_pass_cnt", int'(pass_cnt), 3);

        // Saturation at 3
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 1'b0, 1'b0, 1'b0);
            chk("sat_done", int'(got_done), 1);
            chk("sat_pass_cnt", int'(pass_cnt), 3);
        end

        // Reset while in SLOW1
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_start", int'(start), 1);
        @(posedge clk); #1;
        b = 1'b1;
        @(posedge clk); #1;
        b = 1'b0;
        chk("rstmid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_start_low", int'(start), 0);
        chk("rstmid_busy_low", int'(busy), 0);
        chk("rstmid_ready", int'(req_ready), 1);
        chk("rstmid_cnts", int'({pass_cnt, fail_cnt}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_done = 1'b0; got_err = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) got_done = 1'b1;
            if (err) got_err = 1'b1;
        end
        chk("rstmid_no_resp", int'({got_done, got_err}), 0);
        chk("rstmid_ready_after", int'(req_ready), 1);
        chk("rstmid_cnts_after", int'({pass_cnt, fail_cnt}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
